// File: rtl/leon_inst_feeder.sv
// leon_inst_feeder: FIFO-backed instruction supply for the LEON icache data word and hold handshake.
// Optional macro LEON_FEEDER_NOP_FILL_EN: an empty fetch returns NOP_WORD instead of stalling the core.
module leon_inst_feeder #(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] NOP_WORD = 32'h01000000,
  parameter int          CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_valid,
  input  logic [31:0]            push_inst,
  output logic                   push_ready,
  input  logic                   flush,
  input  logic                   fetch_en,
  output logic [31:0]            inst_out,
  output logic                   inst_valid,
  output logic                   ico_hold,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       issued_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [31:0]      mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [LVL_W-1:0] level_r;
  logic             push_ready_r;
  logic [31:0]      inst_out_r;
  logic             inst_valid_r;
  logic             ico_hold_r;
  logic [CNT_W-1:0] cnt_r;

  logic             push_s;
  logic             pop_s;
  logic             nop_fill_s;
  logic             hold_nxt_s;
  logic             empty_s;
  logic [LVL_W-1:0] level_nxt_s;

  assign empty_s = (level_r == LVL_W'(0));
  // push_ready already excludes the full case, so a push never overruns a pop
  assign push_s  = push_valid && push_ready_r && !flush;

`ifdef LEON_FEEDER_NOP_FILL_EN

  // Fetch decode: empty fetches are answered with a NOP and never stall
  always_comb begin
    pop_s      = 1'b0;
    nop_fill_s = 1'b0;
    hold_nxt_s = 1'b1;
    if (fetch_en && !flush) begin
      if (empty_s) begin
        nop_fill_s = 1'b1;
      end else begin
        pop_s = 1'b1;
      end
    end else begin
      pop_s = 1'b0;
    end
  end

`else

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  state_t state_r;
  state_t state_nxt_s;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: a stalled fetch waits for the first available word, ignoring new strobes
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    nop_fill_s  = 1'b0;
    if (flush) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (fetch_en && empty_s) begin
            state_nxt_s = ST_STALL;
          end else if (fetch_en) begin
            pop_s = 1'b1;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_STALL: begin
          if (!empty_s) begin
            pop_s       = 1'b1;
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_STALL;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
    hold_nxt_s = (state_nxt_s == ST_IDLE);
  end

`endif

  // Occupancy next state
  always_comb begin
    level_nxt_s = level_r;
    case ({push_s, pop_s})
      2'b10:   level_nxt_s = level_r + LVL_W'(1);
      2'b01:   level_nxt_s = level_r - LVL_W'(1);
      default: level_nxt_s = level_r;
    endcase
  end

  // FIFO storage write port
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= push_inst;
    end
  end

  // Pointers, occupancy and registered outputs; flush keeps the issued count
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      level_r      <= '0;
      push_ready_r <= 1'b1;
      inst_out_r   <= NOP_WORD;
      inst_valid_r <= 1'b0;
      ico_hold_r   <= 1'b1;
      cnt_r        <= '0;
    end else if (flush) begin
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      level_r      <= '0;
      push_ready_r <= 1'b1;
      inst_out_r   <= NOP_WORD;
      inst_valid_r <= 1'b0;
      ico_hold_r   <= 1'b1;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r   <= rd_ptr_r + PTR_W'(1);
        inst_out_r <= mem_r[rd_ptr_r];
        cnt_r      <= cnt_r + CNT_W'(1);
      end else if (nop_fill_s) begin
        inst_out_r <= NOP_WORD;
      end
      level_r      <= level_nxt_s;
      push_ready_r <= (level_nxt_s < FULL_LVL);
      inst_valid_r <= pop_s;
      ico_hold_r   <= hold_nxt_s;
    end
  end

  assign push_ready   = push_ready_r;
  assign inst_out     = inst_out_r;
  assign inst_valid   = inst_valid_r;
  assign ico_hold     = ico_hold_r;
  assign level        = level_r;
  assign issued_count = cnt_r;

endmodule

// File: tb/tb_leon_inst_feeder.sv
// Self-checking bench for leon_inst_feeder: queue-based reference model plus directed literal checks.
// Honours LEON_FEEDER_NOP_FILL_EN in the same way as the design.
module tb_leon_inst_feeder;

  localparam int          DEPTH = 8;
  localparam logic [31:0] NOP   = 32'h01000000;
`ifdef LEON_FEEDER_NOP_FILL_EN
  localparam int CNT_AT_FLUSH = 13;
`else
  localparam int CNT_AT_FLUSH = 14;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        push_valid = 1'b0;
  logic [31:0] push_inst = 32'h0;
  logic        flush = 1'b0;
  logic        fetch_en = 1'b0;
  logic        push_ready;
  logic [31:0] inst_out;
  logic        inst_valid;
  logic        ico_hold;
  logic [3:0]  level;
  logic [15:0] issued_count;

  leon_inst_feeder #(.DEPTH(DEPTH), .NOP_WORD(NOP), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .push_valid(push_valid), .push_inst(push_inst),
    .push_ready(push_ready), .flush(flush), .fetch_en(fetch_en),
    .inst_out(inst_out), .inst_valid(inst_valid), .ico_hold(ico_hold),
    .level(level), .issued_count(issued_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of words plus the pending-fetch flag
  logic [31:0] m_q[$];
  bit          m_pend = 1'b0;
  logic [31:0] m_out = 32'h0;
  bit          m_valid = 1'b0;
  bit          m_hold = 1'b1;
  bit          m_ready = 1'b1;
  int unsigned m_cnt = 0;
  bit          m_init = 1'b0;
  bit          d_push;
  bit          d_deliver;

  // Advance the model on each edge, then compare every output once the DUT has settled
  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_pend = 1'b0; m_out = NOP; m_valid = 1'b0; m_hold = 1'b1; m_ready = 1'b1;
      m_cnt = 0; m_init = 1'b1;
    end else if (flush) begin
      m_q.delete();
      m_pend = 1'b0; m_out = NOP; m_valid = 1'b0; m_hold = 1'b1; m_ready = 1'b1;
    end else begin
      d_push    = push_valid && m_ready;
      d_deliver = (m_pend || fetch_en) && (m_q.size() > 0);
      m_valid   = 1'b0;
      if (d_deliver) begin
        m_out   = m_q.pop_front();
        m_valid = 1'b1;
        m_cnt++;
        m_pend  = 1'b0;
      end else if (fetch_en && !m_pend && m_q.size() == 0) begin
`ifdef LEON_FEEDER_NOP_FILL_EN
        m_out = NOP;
`else
        m_pend = 1'b1;
`endif
      end
      if (d_push) m_q.push_back(push_inst);
      m_hold  = !m_pend;
      m_ready = (m_q.size() < DEPTH);
    end
    #1;
    if (m_init) begin
      chk("inst_out",     inst_out, m_out);
      chk("inst_valid",   32'(inst_valid), 32'(m_valid));
      chk("ico_hold",     32'(ico_hold), 32'(m_hold));
      chk("push_ready",   32'(push_ready), 32'(m_ready));
      chk("level",        32'(level), 32'(m_q.size()));
      chk("issued_count", 32'(issued_count), m_cnt & 32'h0000FFFF);
      chk("level_bound",  32'(level <= 4'(DEPTH)), 32'd1);
    end
  end

  task automatic step(input logic pv, input logic [31:0] pi, input logic fl,
                      input logic fe, input logic r);
    @(negedge clk);
    push_valid = pv; push_inst = pi; flush = fl; fetch_en = fe; rst = r;
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [31:0] w);
    step(1'b1, w, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic fetch();
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
  endtask

  logic [31:0] exp_w;

  initial begin
    // Reset held for three cycles
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("rst_inst_out",   inst_out, 32'h01000000);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_ico_hold",   32'(ico_hold), 32'd1);
    chk("rst_push_ready", 32'(push_ready), 32'd1);
    chk("rst_level",      32'(level), 32'd0);
    chk("rst_count",      32'(issued_count), 32'd0);
    idle();

    // Ordering, one-cycle fetch latency
    push(32'h82004002);
    push(32'h8600E001);
    fetch();
    chk("ord_first",       inst_out, 32'h82004002);
    chk("ord_first_valid", 32'(inst_valid), 32'd1);
    fetch();
    chk("ord_second", inst_out, 32'h8600E001);
    chk("ord_count",  32'(issued_count), 32'd2);
    chk("ord_level",  32'(level), 32'd0);
    idle();
    chk("ord_hold_value", inst_out, 32'h8600E001);
    chk("ord_idle_valid", 32'(inst_valid), 32'd0);

    // Fill to DEPTH, drop the extra push, then wrap the pointers
    for (int i = 0; i < 8; i++) push(32'hA0000000 + 32'(i));
    chk("full_ready", 32'(push_ready), 32'd0);
    chk("full_level", 32'(level), 32'd8);
    push(32'hDEADBEEF);
    chk("drop_level", 32'(level), 32'd8);
    for (int i = 0; i < 3; i++) begin
      fetch();
      chk("wrap_pop", inst_out, 32'hA0000000 + 32'(i));
    end
    chk("ready_after_pop", 32'(push_ready), 32'd1);
    for (int i = 0; i < 3; i++) push(32'hB0000000 + 32'(i));
    chk("refill_level", 32'(level), 32'd8);
    for (int i = 0; i < 8; i++) begin
      exp_w = (i < 5) ? (32'hA0000003 + 32'(i)) : (32'hB0000000 + 32'(i - 5));
      fetch();
      chk("wrap_order", inst_out, exp_w);
    end
    chk("wrap_count", 32'(issued_count), 32'd13);
    chk("wrap_level", 32'(level), 32'd0);

    // Fetch on an empty FIFO
    fetch();
`ifdef LEON_FEEDER_NOP_FILL_EN
    chk("fill_inst_out", inst_out, NOP);
    chk("fill_valid",    32'(inst_valid), 32'd0);
    chk("fill_hold",     32'(ico_hold), 32'd1);
    chk("fill_count",    32'(issued_count), 32'd13);
`else
    chk("stall_hold", 32'(ico_hold), 32'd0);
`endif
    idle();
    push(32'hC0062000);
`ifndef LEON_FEEDER_NOP_FILL_EN
    chk("stall_hold_push", 32'(ico_hold), 32'd0);
    chk("stall_no_bypass", 32'(inst_valid), 32'd0);
`endif
    idle();
`ifndef LEON_FEEDER_NOP_FILL_EN
    chk("stall_deliver",       inst_out, 32'hC0062000);
    chk("stall_deliver_valid", 32'(inst_valid), 32'd1);
    chk("stall_release",       32'(ico_hold), 32'd1);
    chk("stall_count",         32'(issued_count), 32'd14);
`endif

    // Flush beats a simultaneous push and fetch
    for (int i = 0; i < 8 && m_q.size() < 5; i++) push($urandom);
    chk("pre_flush_level", 32'(level), 32'd5);
    step(1'b1, 32'h12345678, 1'b1, 1'b1, 1'b0);
    chk("flush_level",    32'(level), 32'd0);
    chk("flush_inst_out", inst_out, NOP);
    chk("flush_valid",    32'(inst_valid), 32'd0);
    chk("flush_hold",     32'(ico_hold), 32'd1);
    chk("flush_ready",    32'(push_ready), 32'd1);
    chk("flush_count",    32'(issued_count), 32'(CNT_AT_FLUSH));
    fetch();
    chk("flush_dropped_push", 32'(inst_valid), 32'd0);

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 1)), $urandom,
           1'($urandom_range(0, 39) == 0),
           1'($urandom_range(0, 9) < 4),
           1'($urandom_range(0, 199) == 0));
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/leon_inst_feeder.md
Name: leon_inst_feeder

Overview:
Instruction-supply stage sitting directly upstream of the LEON integer unit's instruction-cache output port in the testbench interface. Test sequences push 32-bit SPARC instruction words into a FIFO. On each core fetch strobe the block pops one word and presents it as the icache data word, driving the icache hold handshake. When the FIFO is empty the block either stalls the core or fills with NOPs, replacing per-call direct driving of the icache data word.

Parameters:
DEPTH, 8, FIFO entries; power of two, minimum 2
NOP_WORD, 32'h01000000, word supplied on reset, flush and NOP fill (SPARC nop)
CNT_W, 16, width of issued-instruction counter

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
push_valid  input  1  test side offers push_inst
push_inst  input  32  instruction word to enqueue
push_ready  output  1  FIFO can accept a word (registered, = !full)
flush  input  1  discard FIFO contents and any pending fetch
fetch_en  input  1  core fetch strobe (one request per asserted cycle)
inst_out  output  32  instruction word to the icache data field
inst_valid  output  1  inst_out holds a FIFO word delivered this cycle
ico_hold  output  1  icache hold, LEON polarity: 1 = run, 0 = stall core
level  output  $clog2(DEPTH)+1  current FIFO occupancy
issued_count  output  CNT_W  count of FIFO words delivered, wraps at 2^CNT_W

Behaviour:
- Reset (rst=1 at edge): pointers=0, level=0, push_ready=1, inst_out=NOP_WORD, inst_valid=0, ico_hold=1, pending=0, issued_count=0. rst overrides every other input.
- FIFO: circular buffer. wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap DEPTH-1 -> 0.
- Push occurs when push_valid && push_ready at the edge. push_ready is registered from next-state level: 1 iff next level < DEPTH.
- At level==DEPTH, push_ready=0, so no push in the same cycle as a pop. push_ready rises the cycle after the pop.
- No bypass: a push and a fetch in the same cycle on an empty FIFO -> the fetch sees empty. The pushed word is delivered on a later fetch.
- Fetch latency 1: fetch_en at edge n with level>0 -> at edge n+1, inst_out=head word, inst_valid=1, rd_ptr++, level--, issued_count++.
- Cycles with no delivery: inst_valid=0 and inst_out holds its last value.
- Simultaneous push and pop: level unchanged, both pointers advance.
- Empty fetch, macro off: fetch_en with level==0 -> pending=1 and ico_hold=0 from the next edge. fetch_en is ignored while pending.
  - Each cycle pending and level>0: pop, deliver (latency 1 as above), pending=0, ico_hold=1 at the same edge as inst_valid=1.
- State machine: IDLE (pending=0, hold=1) -> STALL on empty fetch. STALL -> IDLE on delivery. Any state -> IDLE on flush or rst.
- flush at edge: pointers=0, level=0, pending=0, ico_hold=1, inst_out=NOP_WORD, inst_valid=0. issued_count is kept.
  - flush beats a push and a fetch in the same cycle; both are dropped.
- level never exceeds DEPTH and never underflows. Verification asserts this.

Optional Feature:
Macro LEON_FEEDER_NOP_FILL_EN.
- Defined: a fetch on an empty FIFO never stalls. Next edge: inst_out=NOP_WORD, inst_valid=0, ico_hold stays 1, issued_count unchanged. The STALL state and the pending register are not built.
- Undefined: stall behaviour as described under Behaviour.

Test Plan:
- Reset: hold rst=1 for 3 cycles, then release -> inst_out=32'h01000000, inst_valid=0, ico_hold=1, push_ready=1, level=0, issued_count=0.
- Order: push 32'h82004002 then 32'h8600E001, then fetch_en two cycles -> inst_out 82004002 then 8600E001, each 1 cycle after its fetch; issued_count=2; level=0.
- Full/wrap: push 8 words (DEPTH=8) -> push_ready=0 at level 8, a 9th push is dropped. Pop 3, push 3 -> pointers wrap and words come out in push order.
- Stall (macro off): fetch on empty -> ico_hold=0 from next cycle. Push 32'hC0062000 two cycles later -> delivered with inst_valid=1 and ico_hold=1 at the same edge.
- NOP fill (macro on): fetch on empty -> inst_out=32'h01000000, ico_hold=1 throughout, issued_count unchanged.
- Flush: level=5 with a push and a fetch in the same cycle as flush=1 -> level=0, inst_out=NOP_WORD, inst_valid=0, ico_hold=1, issued_count retained.
